// File: rtl/sd_cmd_tx_ctrl_if.sv
// sd_cmd_tx_ctrl_if
// Purpose : groups the command handshake, the bit strobe and the CMD pad
//           signals of sd_cmd_tx_ctrl into one bundle.
// Modports:
//   master - command scheduler / pad side: drives bit_en, cmd_valid,
//            cmd_index, cmd_arg, cmd_crc_in; observes cmd_ready, cmd_out,
//            cmd_oe, busy, done.
//   slave  - sd_cmd_tx_ctrl side (directions mirrored).
interface sd_cmd_tx_ctrl_if;
    logic        bit_en;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [6:0]  cmd_crc_in;
    logic        cmd_out;
    logic        cmd_oe;
    logic        busy;
    logic        done;

    modport master (
        output bit_en, cmd_valid, cmd_index, cmd_arg, cmd_crc_in,
        input  cmd_ready, cmd_out, cmd_oe, busy, done
    );

    modport slave (
        input  bit_en, cmd_valid, cmd_index, cmd_arg, cmd_crc_in,
        output cmd_ready, cmd_out, cmd_oe, busy, done
    );
endinterface

// File: rtl/sd_cmd_tx_ctrl.sv
// sd_cmd_tx_ctrl
// Purpose : sends one 48-bit SD CMD-line frame
//           {start 0, tx 1, index[5:0], arg[31:0], crc7[6:0], end 1}
//           MSB-first, one bit per bit_en strobe, then holds the line
//           released for NCC_CYCLES strobes before accepting the next command.
// Ports   :
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   cmd   - sd_cmd_tx_ctrl_if.slave: bit_en strobe, valid/ready command
//           handshake with index/arg/crc_in, CMD pad data/enable, busy, done
// Parameters:
//   NCC_CYCLES - idle strobe periods after the end bit (1..63)
// Build option:
//   CMD_CRC7_EN - when defined the CRC7 (x^7+x^3+1, init 0) is generated
//                 internally over the first 40 frame bits and cmd_crc_in is
//                 ignored; when undefined cmd_crc_in is sent as-is.
//
// state | meaning
// IDLE  | line released high, cmd_ready=1, waiting for cmd_valid
// SEND  | driving the frame, one bit per bit_en strobe
// NCC   | line released, counting the recovery gap strobes
module sd_cmd_tx_ctrl #(
    parameter int unsigned NCC_CYCLES = 8
) (
    input logic           clk,
    input logic           reset,
    sd_cmd_tx_ctrl_if.slave cmd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        NCC  = 2'd2
    } state_t;

    localparam logic [5:0] LAST_BIT = 6'd47;
    localparam logic [5:0] NCC_LAST = 6'(NCC_CYCLES - 1);

    state_t      state;
    logic [47:0] shift_q;
    logic [5:0]  cnt_q;
    logic        cmd_out_q;
    logic        cmd_oe_q;
    logic        cmd_ready_q;
    logic        busy_q;
    logic        done_q;

    logic [6:0]  crc7;
    logic [47:0] frame;

`ifdef CMD_CRC7_EN
    function automatic logic [6:0] crc7_calc(input logic [39:0] data);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = data[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ 7'h09;
            end
        end
        return c;
    endfunction

    always_comb begin
        crc7 = crc7_calc({1'b0, 1'b1, cmd.cmd_index, cmd.cmd_arg});
    end
`else
    always_comb begin
        crc7 = cmd.cmd_crc_in;
    end
`endif

    always_comb begin
        frame = {1'b0, 1'b1, cmd.cmd_index, cmd.cmd_arg, crc7, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            cmd_out_q   <= 1'b1;
            cmd_oe_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_oe_q  <= 1'b0;
                    cmd_out_q <= 1'b1;
                    if (cmd.cmd_valid && cmd_ready_q) begin
                        // Frame is captured whole so later input changes are harmless;
                        // the start bit goes on the line straight away.
                        shift_q     <= frame;
                        cnt_q       <= '0;
                        state       <= SEND;
                        busy_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        cmd_oe_q    <= 1'b1;
                        cmd_out_q   <= frame[47];
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (cmd.bit_en) begin
                        if (cnt_q == LAST_BIT) begin
                            state     <= NCC;
                            cnt_q     <= '0;
                            cmd_oe_q  <= 1'b0;
                            cmd_out_q <= 1'b1;
                        end else begin
                            // Next bit comes from shift_q[46] so the pad sees it on
                            // the same edge the register shifts.
                            shift_q   <= {shift_q[46:0], 1'b0};
                            cmd_out_q <= shift_q[46];
                            cnt_q     <= cnt_q + 6'd1;
                        end
                    end
                end
                NCC: begin
                    if (cmd.bit_en) begin
                        if (cnt_q == NCC_LAST) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cmd.cmd_out   = cmd_out_q;
    assign cmd.cmd_oe    = cmd_oe_q;
    assign cmd.cmd_ready = cmd_ready_q;
    assign cmd.busy      = busy_q;
    assign cmd.done      = done_q;

endmodule

// File: tb/tb_sd_cmd_tx_ctrl.sv
module tb_sd_cmd_tx_ctrl;

    localparam int NCC = 8;

    logic clk;
    logic reset;

    sd_cmd_tx_ctrl_if bus ();

    sd_cmd_tx_ctrl #(.NCC_CYCLES(NCC)) dut (
        .clk   (clk),
        .reset (reset),
        .cmd   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [6:0]  crc_in;
        int          period;
        bit          hold_valid;
        logic [47:0] exp_frame;
        int          exp_oe;      // -1 = not checked
        int          busy_lo;
        int          busy_hi;
        int          exp_gap;     // -1 = not checked
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Entered and left on a negedge. Observes outputs on every negedge and
    // drives inputs right after, so the DUT sees them at the next posedge.
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input logic [6:0] crc, input int period, input bit hold,
                           output logic [47:0] frame, output int nbits,
                           output int oe_cyc, output int busy_cyc, output int gap,
                           output int ready_busy, output int ready_to_oe,
                           output bit tmo);
        int  cyc;
        bit  acc_sched;
        bit  acc_done;
        bit  prev_oe;
        bit  fell;
        bit  finished;
        int  ready_at;
        int  oe_at;
        frame = '0; nbits = 0; oe_cyc = 0; busy_cyc = 0; gap = 0; ready_busy = 0;
        ready_to_oe = -1; tmo = 0;
        cyc = 0; acc_sched = 0; acc_done = 0; prev_oe = 0; fell = 0; finished = 0;
        ready_at = -1; oe_at = -1;
        bus.cmd_index  = idx;
        bus.cmd_arg    = arg;
        bus.cmd_crc_in = crc;
        bus.cmd_valid  = 1'b1;
        while (!finished) begin
            if (acc_done && bus.done) begin
                finished = 1;
            end else begin
                if (bus.cmd_oe && (!prev_oe || bus.bit_en)) begin
                    frame = {frame[46:0], bus.cmd_out};
                    nbits++;
                end
                if (bus.cmd_oe) oe_cyc++;
                if (bus.busy) busy_cyc++;
                if (bus.busy && bus.cmd_ready) ready_busy++;
                if (prev_oe && !bus.cmd_oe) fell = 1;
                if (fell) gap++;
                if (bus.cmd_ready && ready_at < 0) ready_at = cyc;
                if (bus.cmd_oe && oe_at < 0) oe_at = cyc;
                prev_oe = bus.cmd_oe;
                if (acc_sched && !acc_done) begin
                    acc_done = 1;
                    bus.cmd_valid  = hold;
                    bus.cmd_index  = ~idx;
                    bus.cmd_arg    = ~arg;
                    bus.cmd_crc_in = ~crc;
                end else if (!acc_sched && bus.cmd_valid && bus.cmd_ready) begin
                    acc_sched = 1;
                end
                bus.bit_en = ((cyc % period) == (period - 1));
                cyc++;
                if (cyc > 3000) begin
                    tmo = 1;
                    finished = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        if (ready_at >= 0 && oe_at >= 0) ready_to_oe = oe_at - ready_at;
    endtask

    initial begin
        logic [47:0] fr;
        logic [47:0] f17;
        int nb, oe_c, busy_c, gap_c, rb, r2o, done_seen;
        bit tmo;

        reset = 1'b1;
        bus.bit_en = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_index = '0;
        bus.cmd_arg = '0;
        bus.cmd_crc_in = '0;

        vecs.push_back('{"cmd0",   6'd0,  32'h0,     7'h4A, 1, 1'b0, 48'h400000000095, 48, 56, 56, NCC});
        vecs.push_back('{"cmd8",   6'd8,  32'h1AA,   7'h43, 1, 1'b0, 48'h48000001AA87, 48, 56, 56, NCC});
        vecs.push_back('{"cmd17",  6'd17, 32'h0,     7'h2A, 1, 1'b0, 48'h510000000055, 48, 56, 56, NCC});
        vecs.push_back('{"cmd8_p4", 6'd8, 32'h1AA,   7'h43, 4, 1'b0, 48'h48000001AA87, -1, 221, 227, 4*NCC});
`ifdef CMD_CRC7_EN
        vecs.push_back('{"cmd0_crcin", 6'd0, 32'h0,  7'h7F, 1, 1'b0, 48'h400000000095, 48, 56, 56, NCC});
`else
        vecs.push_back('{"cmd0_crcin", 6'd0, 32'h0,  7'h7F, 1, 1'b0, 48'h4000000000FF, 48, 56, 56, NCC});
        vecs.push_back('{"cmd42_p2", 6'd42, 32'hDEADBEEF, 7'h35, 2, 1'b0, 48'h6ADEADBEEF6B, -1, 111, 112, 2*NCC});
`endif
        vecs.push_back('{"hold_a", 6'd17, 32'h0,     7'h2A, 1, 1'b1, 48'h510000000055, 48, 56, 56, NCC});
        vecs.push_back('{"hold_b", 6'd8,  32'h1AA,   7'h43, 1, 1'b1, 48'h48000001AA87, 48, 56, 56, NCC});

        // Reset values while reset is held, then cmd_ready after release.
        repeat (3) @(negedge clk);
        chk("rst_oe",    {63'd0, bus.cmd_oe},    64'd0);
        chk("rst_out",   {63'd0, bus.cmd_out},   64'd1);
        chk("rst_ready", {63'd0, bus.cmd_ready}, 64'd0);
        chk("rst_busy",  {63'd0, bus.busy},      64'd0);
        chk("rst_done",  {63'd0, bus.done},      64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {63'd0, bus.cmd_ready}, 64'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_cmd(vecs[i].idx, vecs[i].arg, vecs[i].crc_in, vecs[i].period, vecs[i].hold_valid,
                    fr, nb, oe_c, busy_c, gap_c, rb, r2o, tmo);
            chk({vecs[i].name, "_timeout"}, {63'd0, tmo}, 64'd0);
            chk({vecs[i].name, "_frame"}, {16'd0, fr}, {16'd0, vecs[i].exp_frame});
            chk({vecs[i].name, "_nbits"}, 64'(nb), 64'd48);
            if (vecs[i].exp_oe >= 0) chk({vecs[i].name, "_oe_cycles"}, 64'(oe_c), 64'(vecs[i].exp_oe));
            chk_rng({vecs[i].name, "_busy_cycles"}, busy_c, vecs[i].busy_lo, vecs[i].busy_hi);
            if (vecs[i].exp_gap >= 0) chk({vecs[i].name, "_ncc_gap"}, 64'(gap_c), 64'(vecs[i].exp_gap));
            chk({vecs[i].name, "_ready_while_busy"}, 64'(rb), 64'd0);
            if (vecs[i].hold_valid) chk({vecs[i].name, "_ready_to_start"}, 64'(r2o), 64'd1);
            chk({vecs[i].name, "_done_busy_low"}, {62'd0, bus.done, bus.busy}, 64'd2);
            @(negedge clk);
            chk({vecs[i].name, "_done_one_clk"}, {63'd0, bus.done}, 64'd0);
        end
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of CMD17 (bit 20 on the line).
        f17 = 48'h510000000055;
        bus.bit_en = 1'b1;
        bus.cmd_index = 6'd17;
        bus.cmd_arg = '0;
        bus.cmd_crc_in = 7'h2A;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("mid_start_bit", {62'd0, bus.cmd_oe, bus.cmd_out}, 64'd2);
        repeat (20) @(negedge clk);
        chk("mid_bit20", {62'd0, bus.cmd_oe, bus.cmd_out}, {62'd0, 1'b1, f17[27]});
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_lines", {62'd0, bus.cmd_oe, bus.cmd_out}, 64'd1);
        chk("mid_rst_busy",  {62'd0, bus.busy, bus.done}, 64'd0);
        reset = 1'b0;
        done_seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        chk("mid_rst_no_done", 64'(done_seen), 64'd0);

        run_cmd(6'd0, 32'h0, 7'h4A, 1, 1'b0, fr, nb, oe_c, busy_c, gap_c, rb, r2o, tmo);
        chk("post_rst_timeout", {63'd0, tmo}, 64'd0);
        chk("post_rst_frame", {16'd0, fr}, {16'd0, 48'h400000000095});
        chk("post_rst_oe_cycles", 64'(oe_c), 64'd48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
